// File: rtl/aes_pkg.sv
// Shared AES types, constants and byte-level helpers for the key schedule and encrypt core.
// Only the key schedule's zeroize build (AES_KS_ZEROIZE_EN) changes behaviour; this package does not.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } ks_state_t;

    localparam int AES256_NK     = 8;
    localparam int AES256_NWORDS = 60;

    localparam logic [7:0] RCON_INIT = 8'h01;

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] xtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] sbox_lookup(input logic [7:0] a);
        return SBOX_TABLE[(255 - int'(a)) * 8 +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_lookup(w[31:24]), sbox_lookup(w[23:16]),
                sbox_lookup(w[15:8]),  sbox_lookup(w[7:0])};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// 8-bit combinational AES forward S-box, shared with the encrypt core's SubBytes.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] s
);

    assign s = sbox_lookup(a);

endmodule

// File: rtl/aes_key_schedule.sv
// AES-256 key expansion: one schedule word per cycle into a 60-word register file with a
// combinational round-key read port. Optional AES_KS_ZEROIZE_EN adds a zeroize input.
module aes_key_schedule
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = 14
) (
    input  logic         clk,
    input  logic         rst_n,
`ifdef AES_KS_ZEROIZE_EN
    input  logic         zeroize,
`endif
    input  logic         start,
    input  logic [255:0] key,
    output logic         busy,
    output logic         keys_valid,
    input  logic [3:0]   rd_round,
    output logic [127:0] rd_key,
    output ks_state_t    dbg_state
);

    // Handshake: start is a level sampled at a clock edge; it is accepted only in IDLE or DONE,
    // and keys_valid stays high until the next accepted start, zeroize or reset.

    logic [31:0] w [AES256_NWORDS];
    logic [5:0]  idx;
    logic [7:0]  rcon;
    ks_state_t   state, state_nxt;
    logic        accept;
    logic        zero_req;
    logic [31:0] prev_w, back_w, sbox_in, sub_out, temp, new_w;
    logic [5:0]  rd_base;

`ifdef AES_KS_ZEROIZE_EN
    assign zero_req = zeroize;
`else
    assign zero_req = 1'b0;
`endif

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        busy       = 1'b0;
        keys_valid = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE:   accept = start;
            EXPAND: begin
                busy = 1'b1;
                if (idx == 6'(AES256_NWORDS - 1)) state_nxt = DONE;
            end
            DONE: begin
                keys_valid = 1'b1;
                accept     = start;
            end
            default: state_nxt = IDLE;
        endcase
        if (accept) state_nxt = EXPAND;
        if (zero_req) begin
            accept    = 1'b0;
            state_nxt = IDLE;
        end
    end

    // Word-generation datapath; rotation only on the first word of each 8-word group.
    assign prev_w  = w[idx - 6'd1];
    assign back_w  = w[idx - 6'(AES256_NK)];
    assign sbox_in = (idx[2:0] == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;

    for (genvar b = 0; b < 4; b++) begin : g_subword
        aes_sbox u_sbox (.a(sbox_in[8*b +: 8]), .s(sub_out[8*b +: 8]));
    end

    always_comb begin
        temp = prev_w;
        if (idx[2:0] == 3'd0)      temp = sub_out ^ {rcon, 24'h0};
        else if (idx[2:0] == 3'd4) temp = sub_out;
        new_w = back_w ^ temp;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || zero_req) begin
            idx  <= '0;
            rcon <= RCON_INIT;
        end else if (accept) begin
            idx  <= 6'(AES256_NK);
            rcon <= RCON_INIT;
        end else if (state == EXPAND) begin
            idx <= idx + 6'd1;
            if (idx[2:0] == 3'd0) rcon <= xtime(rcon);
        end
    end

    always_ff @(posedge clk) begin
`ifdef AES_KS_ZEROIZE_EN
        if (!rst_n || zero_req) begin
            for (int i = 0; i < AES256_NWORDS; i++) w[i] <= '0;
        end else
`endif
        if (rst_n) begin
            if (accept) begin
                for (int i = 0; i < AES256_NK; i++) w[i] <= key[255 - 32*i -: 32];
            end else if (state == EXPAND) begin
                w[idx] <= new_w;
            end
        end
    end

    assign rd_base = {rd_round, 2'b00};
    assign rd_key  = (int'(rd_round) > NUM_ROUNDS) ? 128'h0 :
                     {w[rd_base], w[rd_base + 6'd1], w[rd_base + 6'd2], w[rd_base + 6'd3]};

endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed and randomized bench for aes_key_schedule against a GF(2^8)-derived key-expansion model.
module tb_aes_key_schedule;
    import aes_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [255:0] key = '0;
    logic         busy, keys_valid;
    logic [3:0]   rd_round = '0;
    logic [127:0] rd_key;
    ks_state_t    dbg_state;
`ifdef AES_KS_ZEROIZE_EN
    logic         zeroize = 1'b0;
`endif

    aes_key_schedule #(.NUM_ROUNDS(14)) dut (
        .clk(clk), .rst_n(rst_n),
`ifdef AES_KS_ZEROIZE_EN
        .zeroize(zeroize),
`endif
        .start(start), .key(key), .busy(busy), .keys_valid(keys_valid),
        .rd_round(rd_round), .rd_key(rd_key), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err = 0;
    logic [7:0]  ref_sbox [256];
    logic [31:0] mw [60];
    logic [31:0] exp_q [$];

    localparam logic [255:0] KEY_A3 =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d;
        d = {v, v} << n;
        return d[15:8];
    endfunction

    function automatic logic [31:0] ref_subw(input logic [31:0] t);
        return {ref_sbox[t[31:24]], ref_sbox[t[23:16]], ref_sbox[t[15:8]], ref_sbox[t[7:0]]};
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            ref_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                          ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // FIPS-197 key expansion with Nk = 8; rcon is 2^(i/8 - 1) in GF(2^8).
    task automatic model_expand(input logic [255:0] k);
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 8; i++) mw[i] = k[255 - 32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = mw[i-1];
            if (i % 8 == 0) begin
                rc = 8'h01;
                for (int j = 1; j < i / 8; j++) rc = gmul(rc, 8'h02);
                t = ref_subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            end else if (i % 8 == 4) begin
                t = ref_subw(t);
            end
            mw[i] = mw[i-8] ^ t;
        end
        exp_q = {};
        for (int i = 0; i < 60; i++) exp_q.push_back(mw[i]);
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start for one edge and counts edges until keys_valid rises (-1 on timeout).
    task automatic run_expansion(input logic [255:0] k, output int cycles);
        key = k;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_accept", 128'(busy), 128'(1'b1));
        check("kv_after_accept", 128'(keys_valid), 128'(1'b0));
        cycles = -1;
        for (int n = 1; n <= 70; n++) begin
            tick();
            if (keys_valid) begin
                cycles = n;
                break;
            end
        end
    endtask

    task automatic check_rounds(input string tag);
        logic [127:0] exp;
        for (int r = 0; r < 15; r++) begin
            rd_round = 4'(r);
            #1;
            exp = {exp_q[4*r], exp_q[4*r+1], exp_q[4*r+2], exp_q[4*r+3]};
            check($sformatf("%s_round%0d", tag, r), rd_key, exp);
        end
        rd_round = 4'd15;
        #1;
        check($sformatf("%s_round15_zero", tag), rd_key, 128'h0);
    endtask

    initial begin
        int cyc;
        logic [255:0] rk;

        build_sbox();

        // Reset asserted together with start: reset wins.
        rst_n = 1'b0;
        start = 1'b1;
        key = KEY_A3;
        tick();
        tick();
        start = 1'b0;
        check("reset_state", 128'(dbg_state), 128'(IDLE));
        check("reset_busy", 128'(busy), 128'(1'b0));
        check("reset_kv", 128'(keys_valid), 128'(1'b0));
        rst_n = 1'b1;
        tick();
        check("idle_busy", 128'(busy), 128'(1'b0));

        // FIPS-197 A.3 vector.
        model_expand(KEY_A3);
        run_expansion(KEY_A3, cyc);
        check("a3_latency", 128'(cyc), 128'(52));
        check("a3_state_done", 128'(dbg_state), 128'(DONE));
        check("a3_busy_done", 128'(busy), 128'(1'b0));
        rd_round = 4'd0;  #1; check("a3_r0", rd_key, KEY_A3[255:128]);
        rd_round = 4'd1;  #1; check("a3_r1", rd_key, 128'h1f352c073b6108d72d9810a30914dff4);
        rd_round = 4'd2;  #1; check("a3_r2", rd_key, 128'h9ba354118e6925afa51a8b5f2067fcde);
        rd_round = 4'd14; #1; check("a3_r14", rd_key, 128'hfe4890d1e6188d0b046df344706c631e);
        check_rounds("a3");

        // start held every cycle during EXPAND with changing keys: must be ignored.
        key = KEY_A3;
        start = 1'b1;
        tick();
        cyc = -1;
        for (int n = 1; n <= 70; n++) begin
            start = 1'b1;
            key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            tick();
            if (keys_valid) begin
                start = 1'b0;
                cyc = n;
                break;
            end
        end
        start = 1'b0;
        check("ignore_start_latency", 128'(cyc), 128'(52));
        check_rounds("ignore_start");

        // Restart from DONE with an all-zero key.
        model_expand(256'h0);
        run_expansion(256'h0, cyc);
        check("zero_key_latency", 128'(cyc), 128'(52));
        rd_round = 4'd0; #1; check("zero_key_r0", rd_key, 128'h0);
        check_rounds("zero_key");

        // Reset in the middle of expansion.
        key = KEY_A3;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (19) tick();
        rst_n = 1'b0;
        tick();
        check("midreset_busy", 128'(busy), 128'(1'b0));
        check("midreset_kv", 128'(keys_valid), 128'(1'b0));
        check("midreset_state", 128'(dbg_state), 128'(IDLE));
        rst_n = 1'b1;
        repeat (3) tick();
        check("midreset_stays_idle", 128'(dbg_state), 128'(IDLE));
        model_expand(KEY_A3);
        run_expansion(KEY_A3, cyc);
        check("after_reset_latency", 128'(cyc), 128'(52));
        check_rounds("after_reset");

        // Randomized keys against the reference model.
        for (int t = 0; t < 4; t++) begin
            rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            model_expand(rk);
            run_expansion(rk, cyc);
            check($sformatf("rand%0d_latency", t), 128'(cyc), 128'(52));
            check_rounds($sformatf("rand%0d", t));
        end

`ifdef AES_KS_ZEROIZE_EN
        zeroize = 1'b1;
        tick();
        zeroize = 1'b0;
        check("zeroize_kv", 128'(keys_valid), 128'(1'b0));
        check("zeroize_state", 128'(dbg_state), 128'(IDLE));
        rd_round = 4'd1; #1; check("zeroize_r1", rd_key, 128'h0);
        model_expand(KEY_A3);
        run_expansion(KEY_A3, cyc);
        check("post_zeroize_latency", 128'(cyc), 128'(52));
        zeroize = 1'b1;
        start = 1'b1;
        tick();
        zeroize = 1'b0;
        start = 1'b0;
        check("zeroize_start_state", 128'(dbg_state), 128'(IDLE));
        check("zeroize_start_busy", 128'(busy), 128'(1'b0));
        tick();
        check("zeroize_start_stays", 128'(dbg_state), 128'(IDLE));
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
